// File: rtl/grid_pkg.sv
// Shared colour constants and cursor move encoding for the grid cursor controller.
package grid_pkg;

    localparam logic [11:0] BG_RGB      = 12'h112;
    localparam logic [11:0] LINE_RGB    = 12'hFFF;
    localparam logic [11:0] SEL_RGB     = 12'h0F0;
    localparam logic [11:0] MARK_RGB    = 12'hF00;
    localparam logic [11:0] SELMARK_RGB = 12'hFF0;

    typedef enum logic [2:0] {
        NONE,
        UP,
        DOWN,
        LEFT,
        RIGHT
    } move_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counter-based debouncer and single-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count while the synchronised level disagrees; flip the stable level on the last count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Grid cursor and cell-marking controller: debounced buttons move a cursor and toggle
// per-cell marks; each pixel gets a registered colour from the grid/cursor/mark state.
module grid_cursor_ctrl
    import grid_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned COLS       = 3,
    parameter int unsigned ROWS       = 3,
    parameter int unsigned WRAP       = 0,
    parameter int unsigned DEB_CYCLES = 500000,
    localparam int unsigned CW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
    localparam int unsigned RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [15:0]          xpos_i,
    input  logic [15:0]          ypos_i,
    input  logic                 btn_up_i,
    input  logic                 btn_down_i,
    input  logic                 btn_left_i,
    input  logic                 btn_right_i,
    input  logic                 btn_select_i,
    output logic [3:0]           red_o,
    output logic [3:0]           green_o,
    output logic [3:0]           blue_o,
    output logic [CW-1:0]        cur_col_o,
    output logic [RW-1:0]        cur_row_o,
    output logic [COLS*ROWS-1:0] marks_o
);

    localparam int unsigned CELL_W = H_ACTIVE / COLS;
    localparam int unsigned CELL_H = V_ACTIVE / ROWS;

    logic up_p, down_p, left_p, right_p, sel_p;
    move_e move;

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [COLS*ROWS-1:0] marks_q, marks_d;
    logic [11:0]          rgb_q, rgb_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up    (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_i(btn_up_i),     .press_o(up_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down  (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_i(btn_down_i),   .press_o(down_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_i(btn_left_i),   .press_o(left_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_i(btn_right_i),  .press_o(right_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel   (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_i(btn_select_i), .press_o(sel_p));

    always_comb begin
        move = NONE;
        if (up_p)         move = UP;
        else if (down_p)  move = DOWN;
        else if (left_p)  move = LEFT;
        else if (right_p) move = RIGHT;
    end

    // Select toggles the cell under the pre-move cursor; the move is applied alongside.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        marks_d = marks_q;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (sel_p && row_q == RW'(r) && col_q == CW'(c)) begin
                    marks_d[r*COLS+c] = ~marks_q[r*COLS+c];
                end
            end
        end
        case (move)
            UP: begin
                if (row_q != '0)       row_d = row_q - RW'(1);
                else if (WRAP != 0)    row_d = RW'(ROWS - 1);
            end
            DOWN: begin
                if (row_q != RW'(ROWS - 1)) row_d = row_q + RW'(1);
                else if (WRAP != 0)         row_d = '0;
            end
            LEFT: begin
                if (col_q != '0)       col_d = col_q - CW'(1);
                else if (WRAP != 0)    col_d = CW'(COLS - 1);
            end
            RIGHT: begin
                if (col_q != CW'(COLS - 1)) col_d = col_q + CW'(1);
                else if (WRAP != 0)         col_d = '0;
            end
            default: ;
        endcase
    end

    logic [COLS-1:0] in_col, in_col_s;
    logic [ROWS-1:0] in_row, in_row_s;
    logic            off_area, on_line, cur_hit, cur_marked, mark_hit;

    // Cell membership is decided by comparing against constant boundary products.
    always_comb begin
        in_col     = '0;
        in_col_s   = '0;
        in_row     = '0;
        in_row_s   = '0;
        on_line    = 1'b0;
        cur_hit    = 1'b0;
        cur_marked = 1'b0;
        mark_hit   = 1'b0;
        off_area   = (xpos_i >= 16'(H_ACTIVE)) || (ypos_i >= 16'(V_ACTIVE));
        for (int c = 0; c < int'(COLS); c++) begin
            in_col[c]   = (xpos_i >= 16'(c * CELL_W)) && (xpos_i < 16'((c + 1) * CELL_W));
            in_col_s[c] = (xpos_i >  16'(c * CELL_W)) && (xpos_i < 16'((c + 1) * CELL_W));
            if (c > 0 && xpos_i == 16'(c * CELL_W)) on_line = 1'b1;
        end
        for (int r = 0; r < int'(ROWS); r++) begin
            in_row[r]   = (ypos_i >= 16'(r * CELL_H)) && (ypos_i < 16'((r + 1) * CELL_H));
            in_row_s[r] = (ypos_i >  16'(r * CELL_H)) && (ypos_i < 16'((r + 1) * CELL_H));
            if (r > 0 && ypos_i == 16'(r * CELL_H)) on_line = 1'b1;
        end
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (marks_q[r*COLS+c] && in_row[r] && in_col[c]) mark_hit = 1'b1;
                if (row_q == RW'(r) && col_q == CW'(c)) begin
                    cur_hit    = in_row_s[r] && in_col_s[c];
                    cur_marked = marks_q[r*COLS+c];
                end
            end
        end
        if (off_area)      rgb_d = 12'h000;
        else if (on_line)  rgb_d = LINE_RGB;
        else if (cur_hit)  rgb_d = cur_marked ? SELMARK_RGB : SEL_RGB;
        else if (mark_hit) rgb_d = MARK_RGB;
        else               rgb_d = BG_RGB;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            col_q   <= CW'(COLS / 2);
            row_q   <= RW'(ROWS / 2);
            marks_q <= '0;
            rgb_q   <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            marks_q <= marks_d;
            rgb_q   <= rgb_d;
        end
    end

    assign red_o     = rgb_q[11:8];
    assign green_o   = rgb_q[7:4];
    assign blue_o    = rgb_q[3:0];
    assign cur_col_o = col_q;
    assign cur_row_o = row_q;
    assign marks_o   = marks_q;

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Bench for grid_cursor_ctrl: three instances (3x3 clamp, 3x3 wrap, 4x2 clamp) share stimulus
// and are compared against an arithmetic reference model of cursor, marks and pixel colour.
module tb_grid_cursor_ctrl;
    import grid_pkg::*;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] xpos, ypos;
    logic        b_up, b_dn, b_lf, b_rt, b_sel;

    logic [3:0] r_a, g_a, bl_a, r_b, g_b, bl_b, r_c, g_c, bl_c;
    logic [1:0] col_a, row_a, col_b, row_b, col_c;
    logic [0:0] row_c;
    logic [8:0] marks_a, marks_b;
    logic [7:0] marks_c;

    always #5 clk = ~clk;

    grid_cursor_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480), .COLS(3), .ROWS(3), .WRAP(0), .DEB_CYCLES(D)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .xpos_i(xpos), .ypos_i(ypos),
        .btn_up_i(b_up), .btn_down_i(b_dn), .btn_left_i(b_lf), .btn_right_i(b_rt), .btn_select_i(b_sel),
        .red_o(r_a), .green_o(g_a), .blue_o(bl_a), .cur_col_o(col_a), .cur_row_o(row_a), .marks_o(marks_a));

    grid_cursor_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480), .COLS(3), .ROWS(3), .WRAP(1), .DEB_CYCLES(D)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .xpos_i(xpos), .ypos_i(ypos),
        .btn_up_i(b_up), .btn_down_i(b_dn), .btn_left_i(b_lf), .btn_right_i(b_rt), .btn_select_i(b_sel),
        .red_o(r_b), .green_o(g_b), .blue_o(bl_b), .cur_col_o(col_b), .cur_row_o(row_b), .marks_o(marks_b));

    grid_cursor_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480), .COLS(4), .ROWS(2), .WRAP(0), .DEB_CYCLES(D)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .xpos_i(xpos), .ypos_i(ypos),
        .btn_up_i(b_up), .btn_down_i(b_dn), .btn_left_i(b_lf), .btn_right_i(b_rt), .btn_select_i(b_sel),
        .red_o(r_c), .green_o(g_c), .blue_o(bl_c), .cur_col_o(col_c), .cur_row_o(row_c), .marks_o(marks_c));

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance
    int          ncols[3];
    int          nrows[3];
    int          nwrap[3];
    int          mc[3];
    int          mr[3];
    logic [15:0] mm[3];

    function automatic logic [31:0] dut_col(input int i);
        case (i)
            0:       return 32'(col_a);
            1:       return 32'(col_b);
            default: return 32'(col_c);
        endcase
    endfunction

    function automatic logic [31:0] dut_row(input int i);
        case (i)
            0:       return 32'(row_a);
            1:       return 32'(row_b);
            default: return 32'(row_c);
        endcase
    endfunction

    function automatic logic [31:0] dut_marks(input int i);
        case (i)
            0:       return 32'(marks_a);
            1:       return 32'(marks_b);
            default: return 32'(marks_c);
        endcase
    endfunction

    function automatic logic [31:0] dut_rgb(input int i);
        case (i)
            0:       return 32'({r_a, g_a, bl_a});
            1:       return 32'({r_b, g_b, bl_b});
            default: return 32'({r_c, g_c, bl_c});
        endcase
    endfunction

    function automatic logic [31:0] exp_rgb(input int i, input int x, input int y);
        int  cw, ch, c, r;
        bit  sel, marked;
        cw = 640 / ncols[i];
        ch = 480 / nrows[i];
        if (x >= 640 || y >= 480) return 32'h0;
        if ((x % cw == 0 && x / cw >= 1 && x / cw <= ncols[i] - 1) ||
            (y % ch == 0 && y / ch >= 1 && y / ch <= nrows[i] - 1)) return 32'(LINE_RGB);
        sel = (x > mc[i] * cw) && (x < (mc[i] + 1) * cw) && (y > mr[i] * ch) && (y < (mr[i] + 1) * ch);
        c = x / cw;
        r = y / ch;
        marked = (c < ncols[i]) && (r < nrows[i]) && mm[i][r * ncols[i] + c];
        if (sel) return marked ? 32'(SELMARK_RGB) : 32'(SEL_RGB);
        if (marked) return 32'(MARK_RGB);
        return 32'(BG_RGB);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = ncols[i] / 2;
            mr[i] = nrows[i] / 2;
            mm[i] = '0;
        end
    endtask

    task automatic model_apply(input bit u, input bit d, input bit l, input bit r, input bit s);
        for (int i = 0; i < 3; i++) begin
            if (s) mm[i][mr[i] * ncols[i] + mc[i]] = ~mm[i][mr[i] * ncols[i] + mc[i]];
            if (u) begin
                if (mr[i] > 0) mr[i]--; else if (nwrap[i] != 0) mr[i] = nrows[i] - 1;
            end else if (d) begin
                if (mr[i] < nrows[i] - 1) mr[i]++; else if (nwrap[i] != 0) mr[i] = 0;
            end else if (l) begin
                if (mc[i] > 0) mc[i]--; else if (nwrap[i] != 0) mc[i] = ncols[i] - 1;
            end else if (r) begin
                if (mc[i] < ncols[i] - 1) mc[i]++; else if (nwrap[i] != 0) mc[i] = 0;
            end
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_col%0d", tag, i), dut_col(i), 32'(mc[i]));
            chk($sformatf("%s_row%0d", tag, i), dut_row(i), 32'(mr[i]));
            chk($sformatf("%s_marks%0d", tag, i), dut_marks(i), 32'(mm[i]));
        end
    endtask

    task automatic release_all();
        b_up = 1'b0; b_dn = 1'b0; b_lf = 1'b0; b_rt = 1'b0; b_sel = 1'b0;
    endtask

    // Buttons already driven high; first sampled at the next edge (E0).
    task automatic finish_press(input bit u, input bit d, input bit l, input bit r, input bit s, input int extra);
        repeat (D + 2) step();
        check_state("pre_edge");
        model_apply(u, d, l, r, s);
        step();
        check_state("at_edge");
        repeat (extra) step();
        release_all();
        repeat (D + 4) step();
        check_state("settled");
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r, input bit s, input int extra);
        b_up = u; b_dn = d; b_lf = l; b_rt = r; b_sel = s;
        finish_press(u, d, l, r, s, extra);
    endtask

    task automatic glitch(input bit u, input bit d, input bit l, input bit r, input bit s, input int len);
        b_up = u; b_dn = d; b_lf = l; b_rt = r; b_sel = s;
        repeat (len) step();
        release_all();
        repeat (D + 4) step();
        check_state("glitch");
    endtask

    task automatic pix(input int x, input int y);
        xpos = 16'(x);
        ypos = 16'(y);
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rgb%0d_x%0d_y%0d", i, x, y), dut_rgb(i), exp_rgb(i, x, y));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        model_reset();
        check_state("reset");
        for (int i = 0; i < 3; i++) chk($sformatf("reset_rgb%0d", i), dut_rgb(i), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        int bits, len;
        ncols = '{3, 3, 4};
        nrows = '{3, 3, 2};
        nwrap = '{0, 1, 0};
        model_reset();
        release_all();
        xpos = 16'd0;
        ypos = 16'd0;
        rst_n = 1'b0;

        // Reset state and first pixel after release
        do_reset();
        pix(300, 240);
        chk("reset_pix_sel_a", dut_rgb(0), 32'(SEL_RGB));
        chk("gen_reset_col_c", dut_col(2), 32'd2);
        chk("gen_reset_row_c", dut_row(2), 32'd1);

        // Held Right: one move, timed at E0+D+2
        press(0, 0, 0, 1, 0, 14);
        chk("right_col_a", dut_col(0), 32'd2);
        glitch(0, 0, 0, 1, 0, 3);

        // Clamp vs wrap at the right edge
        press(0, 0, 0, 1, 0, 2);
        chk("clamp_col_a", dut_col(0), 32'd2);
        chk("wrap_col_b", dut_col(1), 32'd0);

        // Up and Left together: only Up applies
        press(1, 0, 1, 0, 0, 1);
        chk("prio_row_a", dut_row(0), 32'd0);
        chk("prio_col_a", dut_col(0), 32'd2);
        press(1, 0, 0, 0, 0, 0);
        chk("wrap_up_row_b", dut_row(1), 32'd2);
        chk("clamp_up_row_a", dut_row(0), 32'd0);

        // Select with Down at (1,1)
        do_reset();
        press(0, 1, 0, 0, 1, 0);
        chk("seldown_marks_a", dut_marks(0), 32'h010);
        chk("seldown_row_a", dut_row(0), 32'd2);

        // Reset during a pending count discards it
        b_rt = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        repeat (2) step();
        release_all();
        repeat (D + 6) step();
        check_state("mid_deb_reset");

        // Button held across reset release is a fresh press
        rst_n = 1'b0;
        b_sel = 1'b1;
        repeat (2) step();
        model_reset();
        rst_n = 1'b1;
        finish_press(0, 0, 0, 0, 1, 0);

        // Colour map with Marks[0] set and cursor at (1,1)
        do_reset();
        press(1, 0, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0, 0);
        press(0, 0, 0, 0, 1, 0);
        press(0, 1, 0, 0, 0, 0);
        press(0, 0, 0, 1, 0, 0);
        pix(213, 50);
        chk("map_line_a", dut_rgb(0), 32'(LINE_RGB));
        pix(100, 50);
        chk("map_mark_a", dut_rgb(0), 32'(MARK_RGB));
        pix(300, 200);
        chk("map_sel_a", dut_rgb(0), 32'(SEL_RGB));
        pix(700, 10);
        chk("map_off_a", dut_rgb(0), 32'h0);
        pix(480, 100);
        chk("gen_line_c", dut_rgb(2), 32'(LINE_RGB));
        pix(0, 0);
        pix(639, 479);
        pix(426, 320);

        // Randomised presses, glitches and pixels
        for (int it = 0; it < 30; it++) begin
            bits = int'($urandom_range(1, 31));
            if ($urandom_range(0, 4) == 0) begin
                len = int'($urandom_range(1, D - 1));
                glitch(bits[0], bits[1], bits[2], bits[3], bits[4], len);
            end else begin
                len = int'($urandom_range(0, 5));
                press(bits[0], bits[1], bits[2], bits[3], bits[4], len);
            end
            for (int p = 0; p < 3; p++) begin
                pix(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
